// File: rtl/serial_pkg.sv
// Shared types and default sizing for the stuffing serial transmitter.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STUFF = 2'd2
    } tx_state_t;

    localparam int DATA_W_DEF  = 8;
    localparam int RUN_MAX_DEF = 3;

endpackage

// File: rtl/run_tracker.sv
// Run-length bookkeeping for the serial line: remembers the last emitted bit and
// how many identical bits in a row have been sent, and flags when a stuff bit is due.
module run_tracker
    import serial_pkg::*;
#(
    parameter  int RUN_MAX = RUN_MAX_DEF,
    localparam int CNT_W   = $clog2(RUN_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             clear,
    output logic             last_bit,
    output logic [CNT_W-1:0] run_cnt,
    output logic             stuff_req
);

    logic             r_last;
    logic [CNT_W-1:0] r_run;
    logic             w_same;
    logic [CNT_W-1:0] w_run_next;

    // stuff_req looks ahead: it reports what the run would become if bit_in were emitted now.
    assign w_same     = (bit_in == r_last) && (r_run != '0);
    assign w_run_next = w_same ? (r_run + CNT_W'(1)) : CNT_W'(1);
    assign stuff_req  = (w_run_next == CNT_W'(RUN_MAX));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last <= 1'b0;
            r_run  <= '0;
        end else if (clear) begin
            r_last <= 1'b0;
            r_run  <= '0;
        end else if (bit_en) begin
            r_last <= bit_in;
            r_run  <= w_run_next;
        end
    end

    assign last_bit = r_last;
    assign run_cnt  = r_run;

endmodule

// File: rtl/stuffing_serial_tx.sv
// MSB-first parallel-to-serial transmitter with bit stuffing after RUN_MAX equal bits.
// Define TX_BACKTOBACK_EN to accept the next word on the last bit of a frame (no idle gap).
module stuffing_serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RUN_MAX = RUN_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              out,
    output logic              out_valid,
    output logic              stuffed,
    output logic              busy
);

    localparam int CNT_W = $clog2(RUN_MAX + 1);
    localparam int BC_W  = $clog2(DATA_W + 1);

    tx_state_t         r_state;
    tx_state_t         w_next;
    logic [DATA_W-1:0] r_shreg;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [BC_W-1:0]   w_cnt_dec;
    logic              w_accept;
    logic              w_bit_in;
    logic              w_bit_en;
    logic              w_clear;
    logic              w_last_bit;
    logic [CNT_W-1:0]  w_run_cnt;
    logic              w_stuff_req;
    logic              w_unused_run;

    // A stuff bit is fed to the tracker like any other bit; being the complement it restarts the run at 1.
    assign w_bit_in  = (r_state == STUFF) ? ~w_last_bit : r_shreg[DATA_W-1];
    assign w_bit_en  = (r_state == SHIFT) || (r_state == STUFF);
    assign w_clear   = (r_state == IDLE);
    assign w_cnt_dec = r_bit_cnt - BC_W'(1);
    assign w_accept  = din_valid && din_ready;

    // The run count is consumed inside the tracker through stuff_req.
    assign w_unused_run = ^w_run_cnt;

    run_tracker #(
        .RUN_MAX (RUN_MAX)
    ) u_run_tracker (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (w_bit_in),
        .bit_en    (w_bit_en),
        .clear     (w_clear),
        .last_bit  (w_last_bit),
        .run_cnt   (w_run_cnt),
        .stuff_req (w_stuff_req)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_stuff_req) begin
                    w_next = STUFF;
                end else if (w_cnt_dec == '0) begin
                    w_next = w_accept ? SHIFT : IDLE;
                end else begin
                    w_next = SHIFT;
                end
            end
            STUFF: begin
                if (r_bit_cnt != '0) begin
                    w_next = SHIFT;
                end else begin
                    w_next = w_accept ? SHIFT : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        din_ready = 1'b0;
        case (r_state)
            IDLE:    din_ready = 1'b1;
`ifdef TX_BACKTOBACK_EN
            SHIFT:   din_ready = (r_bit_cnt == BC_W'(1)) && !w_stuff_req;
            STUFF:   din_ready = (r_bit_cnt == '0);
`endif
            default: din_ready = 1'b0;
        endcase
        busy = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            stuffed   <= 1'b0;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                SHIFT: begin
                    out       <= r_shreg[DATA_W-1];
                    out_valid <= 1'b1;
                    stuffed   <= 1'b0;
                    r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
                    r_bit_cnt <= w_cnt_dec;
                end
                STUFF: begin
                    out       <= ~w_last_bit;
                    out_valid <= 1'b1;
                    stuffed   <= 1'b1;
                end
                default: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    stuffed   <= 1'b0;
                end
            endcase
            // A newly accepted word overrides the shift/count update of the closing frame.
            if (w_accept) begin
                r_shreg   <= din;
                r_bit_cnt <= BC_W'(DATA_W);
            end
        end
    end

endmodule

// File: tb/tb_stuffing_serial_tx.sv
// Scoreboard bench for stuffing_serial_tx: a word-level model queues the expected line
// bits; a monitor compares them against out/stuffed and watches run lengths on the line.
module tb_stuffing_serial_tx;

    localparam int DW = 8;
    localparam int RM = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          out;
    logic          out_valid;
    logic          stuffed;
    logic          busy;

    typedef struct {
        logic b;
        logic s;
        logic last;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   ignore = 1'b1;
    bit   prev_last = 1'b0;
    int   cur_run = 0;
    int   max_run = 0;
    logic run_bit = 1'b0;

    always #5 clk = ~clk;

    stuffing_serial_tx #(
        .DATA_W  (DW),
        .RUN_MAX (RM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .out       (out),
        .out_valid (out_valid),
        .stuffed   (stuffed),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected line content of one word: data bits MSB first, and a complementary
    // extra bit every time RM equal bits in a row have gone out.
    task automatic push_word(input logic [DW-1:0] w);
        int   run  = 0;
        logic prev = 1'b0;
        exp_t e;
        for (int i = DW - 1; i >= 0; i--) begin
            if (run != 0 && w[i] == prev) run++;
            else run = 1;
            prev = w[i];
            e.b = w[i]; e.s = 1'b0; e.last = 1'b0;
            q.push_back(e);
            if (run == RM) begin
                prev = ~prev;
                run  = 1;
                e.b = prev; e.s = 1'b1; e.last = 1'b0;
                q.push_back(e);
            end
        end
        q[q.size()-1].last = 1'b1;
    endtask

    task automatic send(input logic [DW-1:0] w, input bit track);
        int t = 0;
        while (!din_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("din_ready_timeout", {31'd0, din_ready}, 32'd1);
        end else begin
            din       = w;
            din_valid = 1'b1;
            if (track) push_word(w);
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ignore || !reset) begin
            prev_last = 1'b0;
            cur_run   = 0;
        end else begin
`ifndef TX_BACKTOBACK_EN
            if (prev_last) chk("idle_gap_out_valid", {31'd0, out_valid}, 32'd0);
`endif
            prev_last = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_bit: out_valid=1 with out=%0b, expected no bit", out);
                end else begin
                    e = q.pop_front();
                    chk("out_bit", {31'd0, out}, {31'd0, e.b});
                    chk("stuffed", {31'd0, stuffed}, {31'd0, e.s});
`ifndef TX_BACKTOBACK_EN
                    chk("din_ready_in_frame", {31'd0, din_ready}, {31'd0, e.last});
                    prev_last = e.last;
`endif
                end
                if (cur_run > 0 && out == run_bit) cur_run++;
                else cur_run = 1;
                run_bit = out;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
        end
    end

    initial begin
        int nv;
        int t;
        reset     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {31'd0, out}, 32'd0);
        chk("rst_stuffed", {31'd0, stuffed}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_din_ready", {31'd0, din_ready}, 32'd1);
        reset  = 1'b1;
        ignore = 1'b0;
        @(negedge clk);

        send(8'hA5, 1'b1);
        send(8'h00, 1'b1);
        send(8'hF0, 1'b1);
        send(8'h07, 1'b1);
        drain();
        @(negedge clk);

        // Abort a frame of 8'hFF on its 4th line bit.
        ignore = 1'b1;
        send(8'hFF, 1'b0);
        nv = 0;
        t  = 0;
        while (nv < 4 && t < 100) begin
            @(negedge clk);
            if (out_valid) nv++;
            t++;
        end
        chk("abort_bits_seen", nv, 4);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out", {31'd0, out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_din_ready", {31'd0, din_ready}, 32'd1);
        reset  = 1'b1;
        ignore = 1'b0;
        @(negedge clk);

        send(8'hA5, 1'b1);
        send(8'hFF, 1'b1);
        drain();

        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(DW'($urandom), 1'b1);
        end
        drain();
        repeat (2) @(negedge clk);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("max_run_within_limit", {31'd0, (max_run <= RM)}, 32'd1);
        if (max_run > RM) $display("FAIL max_run: got %0d, expected at most %0d", max_run, RM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
